// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: IDLE/RUN/MEM_WAIT/ERR FSM with Mealy-decoded stall, flush and bubble outputs.
// Optional stall performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hd_stall_i,
  input  logic             branch_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_bubble_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] waitCnt_q, waitCnt_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Memory stall dominates load-use stall, which dominates branch flush.
  always_comb begin
    state_d         = state_q;
    waitCnt_d       = waitCnt_q;
    pc_stall_o      = 1'b0;
    if_id_stall_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_stall_o   = 1'b0;
    id_ex_bubble_o  = 1'b0;
    ex_mem_stall_o  = 1'b0;
    mem_wb_bubble_o = 1'b0;
    timeout_o       = 1'b0;
    case (state_q)
      IDLE: begin
        pc_stall_o      = 1'b1;
        if_id_stall_o   = 1'b1;
        id_ex_bubble_o  = 1'b1;
        mem_wb_bubble_o = 1'b1;
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (dmem_req_i && !dmem_ack_i) begin
          pc_stall_o      = 1'b1;
          if_id_stall_o   = 1'b1;
          id_ex_stall_o   = 1'b1;
          ex_mem_stall_o  = 1'b1;
          mem_wb_bubble_o = 1'b1;
          waitCnt_d       = '0;
          state_d         = MEM_WAIT;
        end else if (hd_stall_i) begin
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
        end else if (branch_i) begin
          if_id_flush_o = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A late ack still wins over the timeout in the same cycle.
        if (dmem_ack_i) begin
          state_d = RUN;
        end else begin
          pc_stall_o      = 1'b1;
          if_id_stall_o   = 1'b1;
          id_ex_stall_o   = 1'b1;
          ex_mem_stall_o  = 1'b1;
          mem_wb_bubble_o = 1'b1;
          if (waitCnt_q == WAIT_LAST) state_d = ERR;
          else waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      ERR: begin
        pc_stall_o      = 1'b1;
        if_id_stall_o   = 1'b1;
        id_ex_stall_o   = 1'b1;
        ex_mem_stall_o  = 1'b1;
        mem_wb_bubble_o = 1'b1;
        timeout_o       = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stallCnt_q;

  // Saturating count of stalled cycles while the pipeline is active.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stallCnt_q <= '0;
    end else if ((state_q == RUN || state_q == MEM_WAIT) && pc_stall_o && !(&stallCnt_q)) begin
      stallCnt_q <= stallCnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stallCnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table-driven vectors plus hand-written ack-vs-timeout and async reset sequences.
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;

  logic clk_i = 1'b0;
  logic rst_i, start_i, hd_stall_i, branch_i, dmem_req_i, dmem_ack_i;
  logic pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_bubble_o;
  logic ex_mem_stall_o, mem_wb_bubble_o, timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int compared = 0;
  int mismatched = 0;
  int expCnt = 0;

  // Output bit order: {pc, ifIdStall, ifIdFlush, idExStall, idExBubble, exMemStall, memWbBubble, timeout}
  localparam logic [7:0] O_IDLE = 8'b1100_1010;
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_HAZ  = 8'b1100_1000;
  localparam logic [7:0] O_FLU  = 8'b0010_0000;
  localparam logic [7:0] O_MEM  = 8'b1101_0110;
  localparam logic [7:0] O_ERR  = 8'b1101_0111;

  // Input bit order: {start, hdStall, branch, dmemReq, dmemAck}
  typedef struct packed {
    logic [4:0] in;
    logic [7:0] exp;
    logic       inc;
  } vec_t;

  vec_t vecs[22];

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .hd_stall_i     (hd_stall_i),
    .branch_i       (branch_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ack_i     (dmem_ack_i),
    .pc_stall_o     (pc_stall_o),
    .if_id_stall_o  (if_id_stall_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_stall_o  (id_ex_stall_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .ex_mem_stall_o (ex_mem_stall_o),
    .mem_wb_bubble_o(mem_wb_bubble_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [CNT_W-1:0] cntExpected();
`ifdef PIPE_CTRL_PERF_EN
    return CNT_W'(expCnt);
`else
    return '0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
           id_ex_bubble_o, ex_mem_stall_o, mem_wb_bubble_o, timeout_o};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s outputs: got %b expected %b", name, act, exp);
    end
    compared++;
    if (stall_cnt_o !== cntExpected()) begin
      mismatched++;
      $display("[TB] FAIL %s stall_cnt: got %0d expected %0d", name, stall_cnt_o, cntExpected());
    end
  endtask

  task automatic applyStimulus(input string name, input logic [4:0] in,
                               input logic [7:0] exp, input logic inc);
    @(negedge clk_i);
    {start_i, hd_stall_i, branch_i, dmem_req_i, dmem_ack_i} = in;
    #2;
    checkOutput(name, exp);
    if (inc) expCnt++;
  endtask

  task automatic doReset(input string name);
    @(negedge clk_i);
    {start_i, hd_stall_i, branch_i, dmem_req_i, dmem_ack_i} = 5'b0;
    #2;
    rst_i = 1'b0;
    expCnt = 0;
    #1;
    checkOutput(name, O_IDLE);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    vecs[0]  = {5'b00000, O_IDLE, 1'b0};
    vecs[1]  = {5'b00000, O_IDLE, 1'b0};
    vecs[2]  = {5'b00000, O_IDLE, 1'b0};
    vecs[3]  = {5'b10000, O_IDLE, 1'b0};
    vecs[4]  = {5'b00000, O_NONE, 1'b0};
    vecs[5]  = {5'b01000, O_HAZ,  1'b1};
    vecs[6]  = {5'b00000, O_NONE, 1'b0};
    vecs[7]  = {5'b00100, O_FLU,  1'b0};
    vecs[8]  = {5'b01100, O_HAZ,  1'b1};
    vecs[9]  = {5'b00011, O_NONE, 1'b0};
    vecs[10] = {5'b00110, O_MEM,  1'b1};
    vecs[11] = {5'b01100, O_MEM,  1'b1};
    vecs[12] = {5'b00000, O_MEM,  1'b1};
    vecs[13] = {5'b00101, O_NONE, 1'b0};
    vecs[14] = {5'b00000, O_NONE, 1'b0};
    vecs[15] = {5'b00010, O_MEM,  1'b1};
    vecs[16] = {5'b00000, O_MEM,  1'b1};
    vecs[17] = {5'b00000, O_MEM,  1'b1};
    vecs[18] = {5'b00000, O_MEM,  1'b1};
    vecs[19] = {5'b00000, O_MEM,  1'b1};
    vecs[20] = {5'b10000, O_ERR,  1'b0};
    vecs[21] = {5'b00011, O_ERR,  1'b0};

    rst_i = 1'b0;
    {start_i, hd_stall_i, branch_i, dmem_req_i, dmem_ack_i} = 5'b0;
    #1;
    checkOutput("power_on_reset", O_IDLE);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 22; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp, vecs[i].inc);
    end

    // Ack arriving on the timeout cycle must return to RUN.
    doReset("reset_from_err");
    applyStimulus("ackwin_idle",  5'b10000, O_IDLE, 1'b0);
    applyStimulus("ackwin_req",   5'b00010, O_MEM,  1'b1);
    applyStimulus("ackwin_wait0", 5'b00000, O_MEM,  1'b1);
    applyStimulus("ackwin_wait1", 5'b00000, O_MEM,  1'b1);
    applyStimulus("ackwin_wait2", 5'b00000, O_MEM,  1'b1);
    applyStimulus("ackwin_ack",   5'b01001, O_NONE, 1'b0);
    applyStimulus("ackwin_run",   5'b01000, O_HAZ,  1'b1);
    applyStimulus("ackwin_idle2", 5'b00000, O_NONE, 1'b0);

    // Asynchronous reset between edges while in MEM_WAIT.
    doReset("reset_run");
    applyStimulus("async_start", 5'b10000, O_IDLE, 1'b0);
    applyStimulus("async_req",   5'b00010, O_MEM,  1'b1);
    applyStimulus("async_wait",  5'b00000, O_MEM,  1'b1);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    expCnt = 0;
    #1;
    checkOutput("async_reset_mid_wait", O_IDLE);
    @(negedge clk_i);
    rst_i = 1'b1;
    applyStimulus("post_reset_idle",  5'b00000, O_IDLE, 1'b0);
    applyStimulus("post_reset_start", 5'b10000, O_IDLE, 1'b0);
    applyStimulus("post_reset_run",   5'b00000, O_NONE, 1'b0);
    applyStimulus("post_reset_flush", 5'b00100, O_FLU,  1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum MEM_WAIT cycles without dmem_ack_i before entering ERR; legal range 2..255.
REQ-002 Parameter CNT_W, default 32: width of stall_cnt_o.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  leave IDLE and begin fetching.
REQ-006 hd_stall_i  input  1  load-use hazard request from the hazard detection unit; 1 = stall.
REQ-007 branch_i  input  1  taken branch resolved in ID; 1 = flush IF/ID.
REQ-008 dmem_req_i  input  1  MEM stage is issuing a data-memory access this cycle.
REQ-009 dmem_ack_i  input  1  data memory completes the pending access this cycle.
REQ-010 pc_stall_o  output  1  1 = PC holds its value.
REQ-011 if_id_stall_o  output  1  1 = IF/ID register holds.
REQ-012 if_id_flush_o  output  1  1 = IF/ID loads a NOP.
REQ-013 id_ex_stall_o  output  1  1 = ID/EX register holds.
REQ-014 id_ex_bubble_o  output  1  1 = ID/EX control fields zeroed.
REQ-015 ex_mem_stall_o  output  1  1 = EX/MEM register holds.
REQ-016 mem_wb_bubble_o  output  1  1 = MEM/WB control fields zeroed.
REQ-017 timeout_o  output  1  1 = controller is in ERR.
REQ-018 stall_cnt_o  output  CNT_W  count of stalled cycles.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, MEM_WAIT, ERR, with outputs Mealy-decoded from state and current inputs.
REQ-020 IDLE SHALL assert pc_stall_o, if_id_stall_o, id_ex_bubble_o, mem_wb_bubble_o, and SHALL go to RUN on the first edge with start_i=1.
REQ-021 In RUN with dmem_req_i=1 and dmem_ack_i=0, the block SHALL assert pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o and mem_wb_bubble_o in that same cycle, and SHALL go to MEM_WAIT.
REQ-022 In RUN with dmem_req_i=1 and dmem_ack_i=1, the block SHALL treat the access as zero-wait, assert no memory stall, and stay in RUN.
REQ-023 MEM_WAIT SHALL assert the REQ-021 stall set while dmem_ack_i=0.
REQ-024 In MEM_WAIT, on the first cycle with dmem_ack_i=1, all stall outputs SHALL be deasserted in that cycle and the next state SHALL be RUN.
REQ-025 In MEM_WAIT, hd_stall_i and branch_i SHALL be ignored.
REQ-026 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without ack.
REQ-027 When the wait counter reaches TIMEOUT-1 with dmem_ack_i=0, the next state SHALL be ERR.
REQ-028 An ack arriving in the same cycle as the timeout SHALL win, and the next state SHALL be RUN.
REQ-029 ERR SHALL assert every stall output plus mem_wb_bubble_o and timeout_o until reset; start_i SHALL have no effect in ERR.
REQ-030 In RUN with no memory stall and hd_stall_i=1, the block SHALL assert pc_stall_o, if_id_stall_o and id_ex_bubble_o for exactly the cycles hd_stall_i=1.
REQ-031 In RUN with no memory stall, hd_stall_i=0 and branch_i=1, the block SHALL assert if_id_flush_o only.
REQ-032 Priority SHALL be memory stall > load-use stall > branch flush; a lower-priority action SHALL be suppressed while a higher one is active.
REQ-033 if_id_flush_o and if_id_stall_o SHALL never be 1 in the same cycle.

Reset
REQ-034 rst_i=0 SHALL immediately force IDLE, clear the wait counter, and clear stall_cnt_o, regardless of clock.
REQ-035 While in reset and IDLE, outputs SHALL follow REQ-020: pc_stall_o=1, if_id_stall_o=1, id_ex_bubble_o=1, mem_wb_bubble_o=1, all others 0.
REQ-036 Reset asserted mid-MEM_WAIT SHALL abandon the pending access; no ack tracking is retained.

Configuration
REQ-037 Macro PIPE_CTRL_PERF_EN defined: stall_cnt_o SHALL increment on each clock edge where state is RUN or MEM_WAIT and pc_stall_o=1, saturating at all-ones.
REQ-038 Macro PIPE_CTRL_PERF_EN undefined: stall_cnt_o SHALL be constant 0, no counter flops SHALL be synthesised, and the port SHALL remain present.

Verification
REQ-039 Scenario reset/start: reset, hold start_i=0 for 3 cycles -> pc_stall_o=1 throughout; pulse start_i -> pc_stall_o=0 on the next cycle.
REQ-040 Scenario load-use: hd_stall_i=1 for 1 cycle in RUN -> pc_stall_o=if_id_stall_o=id_ex_bubble_o=1 for that cycle only; stall_cnt_o +1 with PERF enabled.
REQ-041 Scenario branch vs hazard: branch_i=1 with hd_stall_i=0 -> if_id_flush_o=1; branch_i=1 with hd_stall_i=1 -> if_id_flush_o=0, if_id_stall_o=1.
REQ-042 Scenario memory wait: dmem_req_i=1 with ack 3 cycles later -> ex_mem_stall_o=1 for 3 cycles, 0 in the ack cycle; stall_cnt_o +3; concurrent branch_i=1 gives no flush.
REQ-043 Scenario timeout: TIMEOUT=4, dmem_req_i=1, ack never -> timeout_o=1 from the 5th cycle after the request, sticky; start_i ignored; rst_i=0 returns to IDLE.
REQ-044 Scenario async reset: rst_i=0 mid-MEM_WAIT, between clock edges -> IDLE outputs immediately, stall_cnt_o=0.
